// File: rtl/cam_lookup_ctrl.sv
// Request-side controller for a 32-entry CAM: lookup or insert-if-absent with round-robin replacement.
// Define CAM_LOOKUP_CTRL_STATS_EN to build the saturating hit/miss statistics counters.
module cam_lookup_ctrl #(
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_op_i,
  input  logic [31:0]       req_key_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_hit_o,
  output logic [4:0]        rsp_index_o,
  output logic              cam_search_enable_o,
  output logic [31:0]       cam_search_data_o,
  input  logic              cam_search_valid_i,
  input  logic [4:0]        cam_search_index_i,
  output logic              cam_write_enable_o,
  output logic [4:0]        cam_write_index_o,
  output logic [31:0]       cam_write_data_o,
  output logic              full_o,
  output logic [STAT_W-1:0] hit_cnt_o,
  output logic [STAT_W-1:0] miss_cnt_o
);

  typedef enum logic [1:0] {IDLE, SEARCH, WRITE, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] key_q;
  logic        op_q;
  logic        hit_q;
  logic [4:0]  index_q;
  logic [4:0]  victim_q;
  logic [5:0]  occ_q;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Ready is gated by reset so nothing looks acceptable while reset is held.
  always_comb begin
    state_d             = state_q;
    req_ready_o         = 1'b0;
    rsp_valid_o         = 1'b0;
    cam_search_enable_o = 1'b0;
    cam_search_data_o   = '0;
    cam_write_enable_o  = 1'b0;
    cam_write_index_o   = '0;
    cam_write_data_o    = '0;
    case (state_q)
      IDLE: begin
        req_ready_o = ~rst_i;
        if (req_valid_i && !rst_i) state_d = SEARCH;
      end
      SEARCH: begin
        cam_search_enable_o = 1'b1;
        cam_search_data_o   = key_q;
        if (!cam_search_valid_i && op_q) state_d = WRITE;
        else                             state_d = RESP;
      end
      WRITE: begin
        cam_write_enable_o = 1'b1;
        cam_write_index_o  = victim_q;
        cam_write_data_o   = key_q;
        state_d            = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      key_q    <= '0;
      op_q     <= 1'b0;
      hit_q    <= 1'b0;
      index_q  <= '0;
      victim_q <= '0;
      occ_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            key_q <= req_key_i;
            op_q  <= req_op_i;
          end
        end
        SEARCH: begin
          hit_q   <= cam_search_valid_i;
          index_q <= cam_search_valid_i ? cam_search_index_i : 5'd0;
        end
        WRITE: begin
          hit_q    <= 1'b0;
          index_q  <= victim_q;
          victim_q <= victim_q + 5'd1;
          if (occ_q != 6'd32) occ_q <= occ_q + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign rsp_hit_o   = (state_q == RESP) & hit_q;
  assign rsp_index_o = (state_q == RESP) ? index_q : 5'd0;
  assign full_o      = (occ_q == 6'd32);

`ifdef CAM_LOOKUP_CTRL_STATS_EN
  logic [STAT_W-1:0] hit_cnt_q, miss_cnt_q;

  // Every search outcome is counted, including the search that precedes an insert.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == SEARCH) begin
      if (cam_search_valid_i) begin
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cam_lookup_ctrl.sv
// Scoreboard bench for cam_lookup_ctrl with a behavioural 32-entry CAM attached.
// Expectations follow CAM_LOOKUP_CTRL_STATS_EN when it is defined for the build.
module tb_cam_lookup_ctrl;

  localparam int STAT_W = 2;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_op_i;
  logic [31:0]       req_key_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic              rsp_hit_o;
  logic [4:0]        rsp_index_o;
  logic              cam_search_enable_o;
  logic [31:0]       cam_search_data_o;
  logic              cam_search_valid_i;
  logic [4:0]        cam_search_index_i;
  logic              cam_write_enable_o;
  logic [4:0]        cam_write_index_o;
  logic [31:0]       cam_write_data_o;
  logic              full_o;
  logic [STAT_W-1:0] hit_cnt_o;
  logic [STAT_W-1:0] miss_cnt_o;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic       hit;
    logic [4:0] index;
    logic       full;
    logic [1:0] hits;
    logic [1:0] misses;
  } exp_t;

  exp_t        sb[$];
  logic [36:0] wq[$];

  logic [31:0] cam_mem [32];
  logic        cam_vld [32];

  logic [31:0] exp_key [32];
  logic        exp_vld [32];
  logic [4:0]  exp_victim;
  int          exp_occ;
  logic [1:0]  exp_hits, exp_misses;

  cam_lookup_ctrl #(.STAT_W(STAT_W)) dut (
    .clk(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i), .req_key_i(req_key_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_hit_o(rsp_hit_o), .rsp_index_o(rsp_index_o),
    .cam_search_enable_o(cam_search_enable_o), .cam_search_data_o(cam_search_data_o),
    .cam_search_valid_i(cam_search_valid_i), .cam_search_index_i(cam_search_index_i),
    .cam_write_enable_o(cam_write_enable_o), .cam_write_index_o(cam_write_index_o),
    .cam_write_data_o(cam_write_data_o), .full_o(full_o),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk = ~clk;

  // Combinational CAM search; the lowest matching entry wins.
  always_comb begin
    cam_search_valid_i = 1'b0;
    cam_search_index_i = '0;
    for (int i = 31; i >= 0; i--) begin
      if (cam_search_enable_o && cam_vld[i] && cam_mem[i] == cam_search_data_o) begin
        cam_search_valid_i = 1'b1;
        cam_search_index_i = 5'(i);
      end
    end
  end

  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        cam_mem[i] <= '0;
        cam_vld[i] <= 1'b0;
      end
    end else if (cam_write_enable_o) begin
      cam_mem[cam_write_index_o] <= cam_write_data_o;
      cam_vld[cam_write_index_o] <= 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 32; i++) begin
      exp_key[i] = '0;
      exp_vld[i] = 1'b0;
    end
    exp_victim = '0;
    exp_occ    = 0;
    exp_hits   = '0;
    exp_misses = '0;
  endtask

  function automatic logic [1:0] expCnt(input logic [1:0] c);
`ifdef CAM_LOOKUP_CTRL_STATS_EN
    return c;
`else
    return (c & 2'b00);
`endif
  endfunction

  // Called at the moment the DUT accepts a request.
  task automatic modelRequest(input logic op, input logic [31:0] key);
    exp_t e;
    int   m = -1;
    for (int i = 31; i >= 0; i--) if (exp_vld[i] && exp_key[i] == key) m = i;
    if (m >= 0) begin
      e.hit = 1'b1;
      e.index = 5'(m);
      if (exp_hits != 2'd3) exp_hits = exp_hits + 2'd1;
    end else begin
      if (exp_misses != 2'd3) exp_misses = exp_misses + 2'd1;
      e.hit = 1'b0;
      e.index = 5'd0;
      if (op) begin
        e.index = exp_victim;
        exp_key[exp_victim] = key;
        exp_vld[exp_victim] = 1'b1;
        wq.push_back({exp_victim, key});
        exp_victim = exp_victim + 5'd1;
        if (exp_occ < 32) exp_occ++;
      end
    end
    e.full   = (exp_occ == 32);
    e.hits   = expCnt(exp_hits);
    e.misses = expCnt(exp_misses);
    sb.push_back(e);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (sb.size() != 0) checkOutput("rsp_timeout", sb.size(), 0);
  endtask

  task automatic applyStimulus(input logic op, input logic [31:0] key, input bit drain);
    int n = 0;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_key_i   = key;
    while (!req_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_o) begin
      checkOutput("req_timeout", 0, 1);
      req_valid_i = 1'b0;
      return;
    end
    modelRequest(op, key);
    @(negedge clk);
    req_valid_i = 1'b0;
    if (drain) waitDrain();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_ready"}, req_ready_o, 0);
    checkOutput({tag, "_rsp_valid"}, rsp_valid_o, 0);
    checkOutput({tag, "_rsp_hit"}, rsp_hit_o, 0);
    checkOutput({tag, "_rsp_index"}, rsp_index_o, 0);
    checkOutput({tag, "_search_en"}, cam_search_enable_o, 0);
    checkOutput({tag, "_search_data"}, cam_search_data_o, 0);
    checkOutput({tag, "_write_en"}, cam_write_enable_o, 0);
    checkOutput({tag, "_write_idx"}, cam_write_index_o, 0);
    checkOutput({tag, "_write_data"}, cam_write_data_o, 0);
    checkOutput({tag, "_full"}, full_o, 0);
    checkOutput({tag, "_hit_cnt"}, hit_cnt_o, 0);
    checkOutput({tag, "_miss_cnt"}, miss_cnt_o, 0);
  endtask

  // Monitor samples 1 time unit after the falling edge, after inputs have settled.
  always @(negedge clk) begin
    #1;
    if (cam_write_enable_o || cam_search_enable_o)
      checkOutput("enable_excl", cam_write_enable_o & cam_search_enable_o, 0);
    if (cam_write_enable_o) begin
      if (wq.size() == 0) checkOutput("unexpected_write", 1, 0);
      else begin
        logic [36:0] w;
        w = wq.pop_front();
        checkOutput("write_index", cam_write_index_o, w[36:32]);
        checkOutput("write_data", cam_write_data_o, w[31:0]);
      end
    end
    if (rsp_valid_o && rsp_ready_i) begin
      if (sb.size() == 0) checkOutput("unexpected_rsp", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("rsp_hit", rsp_hit_o, e.hit);
        checkOutput("rsp_index", rsp_index_o, e.index);
        checkOutput("rsp_full", full_o, e.full);
        checkOutput("hit_cnt", hit_cnt_o, e.hits);
        checkOutput("miss_cnt", miss_cnt_o, e.misses);
        checkOutput("ready_in_consume", req_ready_o, 0);
      end
    end
  end

  initial begin
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_op_i    = 1'b0;
    req_key_i   = '0;
    rsp_ready_i = 1'b1;
    clearModel();
    repeat (2) @(negedge clk);
    #1;
    checkResetOutputs("rst");
    @(negedge clk);
    rst_i = 1'b0;

    applyStimulus(1'b1, 32'hDEADBEEF, 1'b1);
    applyStimulus(1'b0, 32'hDEADBEEF, 1'b1);
    applyStimulus(1'b0, 32'h12345678, 1'b1);
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b1);

    // Backpressure: the response must hold steady while rsp_ready_i is low.
    @(negedge clk);
    rsp_ready_i = 1'b0;
    applyStimulus(1'b0, 32'hDEADBEEF, 1'b0);
    begin
      int n = 0;
      while (!rsp_valid_o && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    #1;
    checkOutput("hold_reached", rsp_valid_o, 1);
    if (sb.size() != 0) begin
      for (int c = 0; c < 5; c++) begin
        checkOutput("hold_valid", rsp_valid_o, 1);
        checkOutput("hold_hit", rsp_hit_o, sb[0].hit);
        checkOutput("hold_index", rsp_index_o, sb[0].index);
        checkOutput("hold_ready", req_ready_o, 0);
        @(negedge clk);
        #1;
      end
    end
    @(negedge clk);
    rsp_ready_i = 1'b1;
    waitDrain();
    @(negedge clk);
    #1;
    checkOutput("ready_after_consume", req_ready_o, 1);

    applyStimulus(1'b0, 32'hDEADBEEF, 1'b1);
    applyStimulus(1'b0, 32'hDEADBEEF, 1'b1);

    // Abort an insert-miss in its SEARCH cycle, before the write would issue.
    @(negedge clk);
    req_valid_i = 1'b1;
    req_op_i    = 1'b1;
    req_key_i   = 32'hCAFEF00D;
    @(negedge clk);
    req_valid_i = 1'b0;
    #1;
    checkOutput("abort_in_search", cam_search_enable_o, 1);
    rst_i = 1'b1;
    #1;
    checkResetOutputs("abort");
    @(negedge clk);
    #1;
    checkResetOutputs("abort_hold");
    clearModel();
    @(negedge clk);
    rst_i = 1'b0;

    for (int i = 0; i < 33; i++)
      applyStimulus(1'b1, 32'h1000_0000 + 32'(i) * 32'h111, 1'b1);
    applyStimulus(1'b0, 32'h1000_0000 + 32'd5 * 32'h111, 1'b1);
    applyStimulus(1'b0, 32'h1000_0000, 1'b1);
    applyStimulus(1'b0, 32'h1000_0000 + 32'd32 * 32'h111, 1'b1);

    repeat (3) @(negedge clk);
    checkOutput("writes_left", wq.size(), 0);
    checkOutput("rsps_left", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/cam_lookup_ctrl.md
CAM_LOOKUP_CTRL -- requirements
Module: cam_lookup_ctrl

Interface
REQ-001 SHALL have parameter STAT_W, default 16, width of the hit/miss statistics counters.
REQ-002 SHALL have one clock and an asynchronous, active-high reset: clk input 1, the single clock with all state on its rising edge; rst_i input 1, asynchronous active-high reset.
REQ-003 SHALL have port req_valid_i input 1: requester presents an operation.
REQ-004 SHALL have port req_ready_o output 1: controller accepts the operation this cycle.
REQ-005 SHALL have port req_op_i input 1: 0 = lookup, 1 = insert.
REQ-006 SHALL have port req_key_i input 32: key to search or insert.
REQ-007 SHALL have port rsp_valid_o output 1: response available.
REQ-008 SHALL have port rsp_ready_i input 1: requester consumes the response.
REQ-009 SHALL have ports rsp_hit_o output 1 (key already present) and rsp_index_o output 5 (matching or newly written entry).
REQ-010 SHALL have CAM search ports: cam_search_enable_o output 1, cam_search_data_o output 32, cam_search_valid_i input 1, cam_search_index_i input 5.
REQ-011 SHALL have CAM write ports: cam_write_enable_o output 1, cam_write_index_o output 5, cam_write_data_o output 32.
REQ-012 SHALL have status ports: full_o output 1 (all 32 entries written since reset) and hit_cnt_o / miss_cnt_o outputs STAT_W.

Function
REQ-013 SHALL implement FSM states IDLE, SEARCH, WRITE, RESP.
REQ-014 SHALL assert req_ready_o only in IDLE; acceptance = req_valid_i & req_ready_o, which registers the key and op and moves to SEARCH.
REQ-015 SHALL drive cam_search_enable_o=1 with cam_search_data_o=registered key for exactly one cycle in SEARCH, sampling cam_search_valid_i/cam_search_index_i at the end of that cycle (CAM search result is combinational).
REQ-016 SEARCH hit: SHALL move to RESP with rsp_hit_o=1 and rsp_index_o=cam_search_index_i; no write.
REQ-017 SEARCH miss with lookup: SHALL move to RESP with rsp_hit_o=0 and rsp_index_o=0.
REQ-018 SEARCH miss with insert: SHALL move to WRITE and, for one cycle, drive cam_write_enable_o=1, cam_write_index_o=victim pointer, cam_write_data_o=key; then RESP with rsp_hit_o=0 and rsp_index_o=the written index.
REQ-019 The victim pointer (5 bits) SHALL increment by 1 after each WRITE, wrapping 31->0 (round-robin replacement; entries are overwritten once full).
REQ-020 An occupancy counter (6 bits, 0..32) SHALL increment on each WRITE, saturate at 32, and drive full_o=1 at 32.
REQ-021 In RESP, rsp_valid_o SHALL be 1 and the outputs held stable until rsp_ready_i=1, then return to IDLE; best-case accept-to-response latency is 2 cycles for hit/lookup and 3 for insert-miss.
REQ-022 The CAM write and search enables SHALL never be asserted in the same cycle and SHALL be 0 outside SEARCH/WRITE.
REQ-023 A new request SHALL NOT be accepted in the cycle the response is consumed; req_ready_o rises the following cycle (IDLE).

Reset
REQ-024 rst_i SHALL asynchronously force IDLE, victim pointer 0, occupancy 0, and statistics 0.
REQ-025 During reset: req_ready_o=0, rsp_valid_o=0, rsp_hit_o=0, rsp_index_o=0, all cam_* outputs 0, full_o=0.
REQ-026 Reset asserted mid-operation SHALL abort it with no CAM write issued after assertion and no response delivered.

Configuration
REQ-027 Macro CAM_LOOKUP_CTRL_STATS_EN defined: hit_cnt_o counts SEARCH hits and miss_cnt_o counts SEARCH misses, each saturating at 2^STAT_W-1.
REQ-028 Macro CAM_LOOKUP_CTRL_STATS_EN undefined: the counters SHALL NOT be built and hit_cnt_o/miss_cnt_o SHALL be tied to 0.

Verification
REQ-029 Insert key 0xDEADBEEF after reset -> search miss, write index 0, response hit=0 index=0, full_o=0.
REQ-030 Lookup 0xDEADBEEF afterwards (CAM model returns index 0) -> response hit=1 index=0, no cam_write_enable_o pulse.
REQ-031 33 distinct inserts -> writes to indices 0..31 then 0, full_o=1 from the 32nd response onward.
REQ-032 Hold rsp_ready_i=0 for 5 cycles -> rsp_valid_o, rsp_hit_o and rsp_index_o stay stable, req_ready_o=0.
REQ-033 Assert rst_i in the WRITE-bound cycle of an insert -> no write, all outputs at reset values, pointer 0.
REQ-034 With CAM_LOOKUP_CTRL_STATS_EN and STAT_W=2, drive 5 hits -> hit_cnt_o saturates at 3; without the macro both counters read 0.
